// File: rtl/event_counter_display.sv
// ---------------------------------------------------------------------------
// event_counter_display
//
// Counts rising edges on an asynchronous trigger input in a DIGITS-wide BCD
// counter and shows the count on a multiplexed seven-segment display.
// Leading zeros are blanked.
//
// Parameters
//   DIGITS      : number of BCD digits / anodes (1..8)
//   REFRESH_DIV : clk cycles each digit stays lit (>= 2)
//   ACTIVE_LOW  : 1 -> seven and AN are active-low, 0 -> active-high
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : asynchronous active-high reset
//   trigger   : asynchronous event input, one event per rising edge
//   clear     : synchronous clear of count and overflow
//   hold      : freeze the displayed value; counting continues
//   seven     : segment drive, bit0=a .. bit6=g
//   AN        : anode drive, AN[0] = least significant digit
//   bcd_value : live count, digit i in bits [4i+3:4i]
//   overflow  : sticky flag, set when the counter wraps from all nines
// ---------------------------------------------------------------------------
module event_counter_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  clear,
  input  logic                  hold,
  output logic [6:0]            seven,
  output logic [DIGITS-1:0]     AN,
  output logic [4*DIGITS-1:0]   bcd_value,
  output logic                  overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  // Outputs come out of reset already showing "0" on digit 0, which is
  // exactly what the first clock edge after release would produce.
  localparam logic [6:0]        SEVEN_RST = ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_RST    = ACTIVE_LOW ? ~AN_ONE : AN_ONE;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Trigger synchroniser and edge detect. All three flops reset to 1 so a
  // trigger that is already high when reset releases does not look like an
  // edge.
  // -------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic edge_reg;
  logic event_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      edge_reg <= 1'b1;
    end else begin
      sync1    <= trigger;
      sync2    <= sync1;
      edge_reg <= sync2;
    end
  end

  assign event_pulse = sync2 & ~edge_reg;

  // -------------------------------------------------------------------------
  // BCD counter: ripple carry through the digits within a single cycle.
  // carry[DIGITS] is the wrap out of the top digit.
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] count;
  logic [DIGITS-1:0][3:0] count_next;
  logic [DIGITS:0]        carry;

  assign carry[0] = event_pulse;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign carry[gi+1]    = carry[gi] && (count[gi] == 4'd9);
      assign count_next[gi] = !carry[gi]           ? count[gi] :
                              (count[gi] == 4'd9)  ? 4'd0      :
                                                     count[gi] + 4'd1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      // clear wins over a coincident event; that event is dropped
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (carry[DIGITS]) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bcd_value = count;

  // -------------------------------------------------------------------------
  // Display register and leading-zero blanking
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] disp;
  logic [DIGITS-1:0]      upper_zero;  // this digit and all above are zero
  logic [DIGITS-1:0]      blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp <= '0;
    end else if (!hold) begin
      disp <= count;
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = (disp[gi] == 4'd0);
      end else begin : g_lower
        assign upper_zero[gi] = (disp[gi] == 4'd0) && upper_zero[gi+1];
      end
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_msd
        assign blank[gi] = upper_zero[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Refresh timer and digit index
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] digit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output stage. Segments and anode are both derived from the same
  // digit_idx and registered on the same edge, so they always change
  // together.
  // -------------------------------------------------------------------------
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [6:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_hi     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_digit = disp[i];
        cur_blank = blank[i];
        an_hi[i]  = 1'b1;
      end
    end
    seg_hi = cur_blank ? 7'b0000000 : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seven <= SEVEN_RST;
      AN    <= AN_RST;
    end else begin
      seven <= ACTIVE_LOW ? ~seg_hi : seg_hi;
      AN    <= ACTIVE_LOW ? ~an_hi  : an_hi;
    end
  end

endmodule

// File: tb/tb_event_counter_display.sv
// ---------------------------------------------------------------------------
// tb_event_counter_display
//
// Directed bench for event_counter_display with DIGITS=4, REFRESH_DIV=4,
// ACTIVE_LOW=1. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_event_counter_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic        clear;
  logic        hold;
  logic [6:0]  seven;
  logic [3:0]  AN;
  logic [15:0] bcd_value;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Active-low segment constants (gfedcba inverted)
  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_0     = 7'h40;
  localparam logic [6:0] S_1     = 7'h79;
  localparam logic [6:0] S_2     = 7'h24;
  localparam logic [6:0] S_3     = 7'h30;
  localparam logic [6:0] S_7     = 7'h78;

  event_counter_display #(
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .clear     (clear),
    .hold      (hold),
    .seven     (seven),
    .AN        (AN),
    .bcd_value (bcd_value),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // n clean pulses: 2 cycles high, 2 cycles low
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      trigger = 1'b1;
      repeat (2) @(negedge clk);
      trigger = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // Watch a full scan and record the segments shown for each anode
  task automatic scan(output logic [3:0][6:0] segs);
    segs = {4{7'h2A}};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (AN[j] == 1'b0) segs[j] = seven;
      end
    end
  endtask

  logic [3:0][6:0] segs;
  logic [3:0]      an_exp [4];
  logic [3:0]      prev_an;
  bit              found;

  initial begin
    an_exp[0] = 4'b1101;
    an_exp[1] = 4'b1011;
    an_exp[2] = 4'b0111;
    an_exp[3] = 4'b1110;

    // Reset with trigger already high
    reset   = 1'b1;
    trigger = 1'b1;
    clear   = 1'b0;
    hold    = 1'b0;
    #3;
    check("rst_bcd",   32'(bcd_value), 32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_an",    32'(AN),        32'hE);
    check("rst_seven", 32'(seven),     32'(S_0));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_an",    32'(AN),    32'hE);
    check("first_seven", 32'(seven), 32'(S_0));
    repeat (5) @(negedge clk);
    check("trig_high_thru_rst", 32'(bcd_value), 32'h0);
    trigger = 1'b0;
    repeat (3) @(negedge clk);

    // 123 events and the scanned display
    pulse(123);
    check("count_123", 32'(bcd_value), 32'h0123);
    scan(segs);
    check("scan123_d3", 32'(segs[3]), 32'(S_BLANK));
    check("scan123_d2", 32'(segs[2]), 32'(S_1));
    check("scan123_d1", 32'(segs[1]), 32'(S_2));
    check("scan123_d0", 32'(segs[0]), 32'(S_3));

    // Anode stepping: find the start of a digit-0 slot, then step by 4
    found   = 1'b0;
    prev_an = AN;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (prev_an != 4'hE && AN == 4'hE) found = 1'b1;
      prev_an = AN;
    end
    check("scan_start", 32'(found), 32'h1);
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("an_hold%0d", k), 32'(AN), 32'(k == 0 ? 4'hE : an_exp[k-1]));
        @(negedge clk);
        check($sformatf("an_step%0d", k), 32'(AN), 32'(an_exp[k]));
      end
    end

    // Clear, then 42 events, then clear coinciding with an event
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_bcd", 32'(bcd_value), 32'h0);
    pulse(42);
    check("count_42", 32'(bcd_value), 32'h0042);
    trigger = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_vs_evt", 32'(bcd_value), 32'h0);
    repeat (3) @(negedge clk);
    check("clr_evt_lost", 32'(bcd_value), 32'h0);
    trigger = 1'b0;
    repeat (2) @(negedge clk);

    // Hold: freeze "7" while counting to 12
    pulse(7);
    repeat (2) @(negedge clk);
    hold = 1'b1;
    pulse(5);
    check("hold_bcd", 32'(bcd_value), 32'h0012);
    scan(segs);
    check("hold_d0", 32'(segs[0]), 32'(S_7));
    check("hold_d1", 32'(segs[1]), 32'(S_BLANK));
    hold = 1'b0;
    @(negedge clk);
    scan(segs);
    check("unhold_d0", 32'(segs[0]), 32'(S_2));
    check("unhold_d1", 32'(segs[1]), 32'(S_1));
    check("unhold_d2", 32'(segs[2]), 32'(S_BLANK));

    // Full range and overflow
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulse(9999);
    check("count_9999", 32'(bcd_value), 32'h9999);
    check("ovf_before", 32'(overflow),  32'h0);
    pulse(1);
    check("wrap_bcd",   32'(bcd_value), 32'h0000);
    check("wrap_ovf",   32'(overflow),  32'h1);
    pulse(2);
    check("ovf_sticky_bcd", 32'(bcd_value), 32'h0002);
    check("ovf_sticky",     32'(overflow),  32'h1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("ovf_cleared", 32'(overflow),  32'h0);
    check("clr2_bcd",    32'(bcd_value), 32'h0);

    // Reset mid-scan
    pulse(5);
    check("count_5", 32'(bcd_value), 32'h0005);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (AN == 4'b1011) found = 1'b1;
    end
    check("midscan_found", 32'(found), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_an",    32'(AN),        32'hE);
    check("async_rst_seven", 32'(seven),     32'(S_0));
    check("async_rst_bcd",   32'(bcd_value), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_bcd", 32'(bcd_value), 32'h0);
    check("post_rst_an",  32'(AN),        32'hE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
